// File: rtl/ahb_lite_master_if.sv
// Bundle of command/response stream and AHB-Lite bus signals for ahb_lite_master.
// Latency: none, wires only.
// Backpressure: cmd side uses cmd_ready; rsp side has none; AHB side uses HREADY.
interface ahb_lite_master_if;
    // command stream
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_wdata;
    // response stream
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    // AHB-Lite bus
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    // Initiator view: consumes commands and bus replies, drives responses and bus requests.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    // Environment view: command producer, response consumer and bus slave.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands -> NONSEQ SINGLE transfers, in-order responses.
// Latency: accept edge E, address phase E..E+1, data phase E+1..E+2, rsp_valid in the cycle after E+2.
// Backpressure: cmd_ready drops while the address slot is full and HREADY is low; responses cannot stall.
module ahb_lite_master #(
    parameter int RDATA_ALIGN = 1,
    parameter int WDATA_ALIGN = 1
) (
    input  logic               HCLK,
    input  logic               HRESET,
    ahb_lite_master_if.master  bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    // Address-phase slot: the registered AHB address outputs double as its storage.
    logic        a_vld;
    logic        a_mis;
    logic [31:0] a_wdata;
    logic [31:0] haddr_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;

    // Data-phase slot: only what is needed to finish the transfer and format the reply.
    logic        d_vld;
    logic        d_write;
    logic        d_mis;
    logic [1:0]  d_lo;
    logic [1:0]  d_size;
    logic [31:0] hwdata_q;

    // Response registers.
    logic        rsp_valid_q;
    logic        rsp_write_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        cmd_ready;
    logic        cmd_fire;
    logic        cmd_mis;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;

    // Place write data on the byte lanes the slave will sample.
    function automatic logic [31:0] wr_lanes(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (WDATA_ALIGN != 0) begin
            case (sz)
                2'd0:    r = {4{d[7:0]}};
                2'd1:    r = {2{d[15:0]}};
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // Right-justify and zero-extend the addressed lanes of HRDATA.
    function automatic logic [31:0] rd_fmt(input logic [31:0] raw, input logic [1:0] lo,
                                           input logic [1:0] sz);
        logic [31:0] sh;
        logic [31:0] r;
        sh = raw >> {lo, 3'b000};
        r  = raw;
        if (RDATA_ALIGN != 0) begin
            case (sz)
                2'd0:    r = {24'h0, sh[7:0]};
                2'd1:    r = {16'h0, sh[15:0]};
                default: r = sh;
            endcase
        end
        return r;
    endfunction

    // A new command may enter whenever the address slot is free or leaves this edge.
    assign cmd_ready = !HRESET && (!a_vld || bus.HREADY);
    assign cmd_fire  = bus.cmd_valid && cmd_ready;

    // Size 3 and unnaturally aligned half/word accesses never reach the bus.
    assign cmd_mis = (bus.cmd_size == 2'd3) ||
                     ((bus.cmd_size == 2'd1) && bus.cmd_addr[0]) ||
                     ((bus.cmd_size == 2'd2) && (bus.cmd_addr[1:0] != 2'b00));

    assign d_done  = d_vld && bus.HREADY;
    assign d_err   = d_mis || bus.HRESP;
    assign d_rdata = (d_write || d_err) ? 32'h0 : rd_fmt(bus.HRDATA, d_lo, d_size);

    // Address slot: load on accept, retire to IDLE when the bus takes it with nothing behind.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_vld    <= 1'b0;
            a_mis    <= 1'b0;
            a_wdata  <= 32'h0;
            haddr_q  <= 32'h0;
            htrans_q <= TR_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b000;
        end else if (cmd_fire) begin
            a_vld    <= 1'b1;
            a_mis    <= cmd_mis;
            a_wdata  <= wr_lanes(bus.cmd_size, bus.cmd_wdata);
            haddr_q  <= bus.cmd_addr;
            htrans_q <= cmd_mis ? TR_IDLE : TR_NONSEQ;
            hwrite_q <= bus.cmd_write;
            hsize_q  <= {1'b0, bus.cmd_size};
        end else if (bus.HREADY) begin
            a_vld    <= 1'b0;
            htrans_q <= TR_IDLE;
        end
    end

    // Data slot: follows the address slot on every HREADY edge; write data is held until then.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_vld    <= 1'b0;
            d_write  <= 1'b0;
            d_mis    <= 1'b0;
            d_lo     <= 2'b00;
            d_size   <= 2'b00;
            hwdata_q <= 32'h0;
        end else if (bus.HREADY) begin
            d_vld   <= a_vld;
            d_write <= hwrite_q;
            d_mis   <= a_mis;
            d_lo    <= haddr_q[1:0];
            d_size  <= hsize_q[1:0];
            if (a_vld && hwrite_q && !a_mis) begin
                hwdata_q <= a_wdata;
            end
        end
    end

    // Response: one-cycle strobe after the data phase completes; fields are zero otherwise.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else if (d_done) begin
            rsp_valid_q <= 1'b1;
            rsp_write_q <= d_write;
            rsp_err_q   <= d_err;
            rsp_rdata_q <= d_rdata;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.HADDR     = haddr_q;
    assign bus.HTRANS    = htrans_q;
    assign bus.HWRITE    = hwrite_q;
    assign bus.HSIZE     = hsize_q;
    assign bus.HWDATA    = hwdata_q;

endmodule
